inst_mem_sync: RTL and testbench

- Parametrised, writable successor to the combinational instruction ROM.
- Holds DEPTH words in synchronous RAM and serves the IF stage through a request/response handshake with 1-cycle latency and stall hold.
- Flags misaligned or out-of-range fetches.
- Can be reprogrammed at run time (bootloader port) or bulk-filled by an internal clear sequencer.

---
 rtl/inst_mem_pkg.sv | 25 ++
 rtl/inst_mem_array.sv | 38 +++
 rtl/inst_mem_sync.sv | 137 +++++++++++++
 tb/tb_inst_mem_sync.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
package inst_mem_pkg;

    // Controller states: normal fetch service, or bulk fill sweep
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // MIPS nop, the default fill pattern
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Number of index bits needed to address 'value' words
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x DATA_W RAM: one synchronous read port, one write port.
// A read and write to the same index on the same edge returns the old word.
module inst_mem_array
    import inst_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read register: loads only on a read so a stalled response stays put
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/inst_mem_sync.sv
// Writable instruction memory serving the IF stage with a 1-cycle
// request/response handshake, fault flagging, a bootloader write port
// and an internal clear sequencer.
module inst_mem_sync
    import inst_mem_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                DEPTH          = 256,
    parameter logic [31:0]       BASE_ADDR      = 32'h0000_0000,
    parameter logic [DATA_W-1:0] FILL_WORD      = DATA_W'(NOP_WORD),
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_req,
    input  logic [31:0]             fetch_addr,
    output logic                    fetch_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_instr,
    output logic                    rsp_fault,
    input  logic                    prog_we,
    input  logic [clog2(DEPTH)-1:0] prog_addr,
    input  logic [DATA_W-1:0]       prog_data,
    input  logic                    clr_req,
    output logic                    busy,
    output logic [7:0]              fault_cnt
);

    localparam int          IDX_W       = clog2(DEPTH);
    localparam logic [33:0] LIMIT       = 34'(DEPTH) << 2;
    localparam state_t      RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t              state;
    logic [IDX_W-1:0]    cnt;
    logic [31:0]         off;
    logic                fault;
    logic                accept;
    logic [IDX_W-1:0]    fetch_idx;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   ram_data;

    // Address decode relative to the memory base (wraps modulo 2^32)
    assign off       = fetch_addr - BASE_ADDR;
    assign fault     = (off[1:0] != 2'b00) || ({2'b00, off} >= LIMIT);
    assign fetch_idx = off[IDX_W+1:2];

    // Handshake: a held response blocks new fetches until it is consumed
    assign fetch_ready = (state == ST_RUN) && (!rsp_valid || rsp_ready);
    assign accept      = fetch_req && fetch_ready;
    assign busy        = (state == ST_CLEAR);

    // Faulted responses never depend on RAM contents
    assign rsp_instr = rsp_fault ? FILL_WORD : ram_data;

    // Write port owner: clear sweep takes precedence, prog port only in RUN
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = prog_addr;
        wr_data = prog_data;
        if (state == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = cnt;
            wr_data = FILL_WORD;
        end else begin
            wr_en   = prog_we;
        end
    end

    inst_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (accept && !fault),
        .rd_idx  (fetch_idx),
        .rd_data (ram_data),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data)
    );

    // Controller: RUN waits for clr_req, CLEAR walks every index once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RESET_STATE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == IDX_W'(DEPTH - 1)) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + IDX_W'(1);
                    end
                end
                default: begin
                    state <= RESET_STATE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Response register: load on accept, drop once consumed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= fault;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Saturating count of accepted faulted fetches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_cnt <= 8'd0;
        end else if (accept && fault && (fault_cnt != 8'hFF)) begin
            fault_cnt <= fault_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_inst_mem_sync.sv
// Scoreboard bench for inst_mem_sync: driver pushes expected responses
// from a word-array reference model, a monitor pops on each handshake.
module tb_inst_mem_sync;

    localparam int          DEPTH  = 256;
    localparam int          DATA_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] FILL   = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        bit          fault;
    } rsp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic              rsp_fault;
    logic              prog_we;
    logic [7:0]        prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              clr_req;
    logic              busy;
    logic [7:0]        fault_cnt;

    int          checks = 0;
    int          passed = 0;
    rsp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          fcnt = 0;
    bit          mvalid = 0;

    inst_mem_sync #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .FILL_WORD(FILL), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_fault(rsp_fault), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .clr_req(clr_req), .busy(busy), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference: a fetch is a fault when misaligned or beyond the word array
    function automatic rsp_t expect_fetch(input logic [31:0] addr);
        rsp_t        r;
        logic [31:0] off;
        off = addr - BASE;
        r.fault = ((off % 4) != 0) || (longint'(off) >= 4 * DEPTH);
        r.instr = r.fault ? FILL : model[off / 4];
        return r;
    endfunction

    // One clock of stimulus, entered and left at posedge+1
    task automatic step(input bit req, input logic [31:0] addr, input bit we,
                        input int widx, input logic [31:0] wdata, input bit clr);
        rsp_t r;
        fetch_req = req; fetch_addr = addr; prog_we = we;
        prog_addr = widx[7:0]; prog_data = wdata; clr_req = clr;
        @(negedge clk);
        if (req && fetch_ready) begin
            r = expect_fetch(addr);
            sb.push_back(r);
            if (r.fault && fcnt < 255) fcnt++;
        end
        if (we && !busy) model[widx] = wdata;
        @(posedge clk); #1;
        fetch_req = 1'b0; prog_we = 1'b0; clr_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 32'h0, 0);
    endtask

    // Count sweep cycles while hammering prog_we/clr_req, which must be ignored
    task automatic sweep_check(input string name);
        int n;
        bit done;
        bit ready_seen;
        n = 0; done = 0; ready_seen = 0;
        prog_we = 1'b1; prog_addr = 8'd2; prog_data = 32'h1234_5678; clr_req = 1'b1;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
            else begin
                n++;
                if (fetch_ready) ready_seen = 1;
            end
        end
        prog_we = 1'b0; clr_req = 1'b0;
        chk({name, "_busy_cycles"}, n, DEPTH);
        chk({name, "_fetch_ready_in_clear"}, ready_seen, 0);
        @(posedge clk); #1;
        for (int k = 0; k < DEPTH; k++) model[k] = FILL;
    endtask

    // Monitor: track expected rsp_valid and compare each consumed response
    always @(negedge clk) begin
        rsp_t e;
        if (!reset) begin
            sb.delete();
            mvalid = 0;
        end else begin
            chk("rsp_valid", rsp_valid, mvalid);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_instr", rsp_instr, e.instr);
                    chk("rsp_fault", rsp_fault, e.fault);
                end
            end
            if (fetch_req && fetch_ready) mvalid = 1;
            else if (rsp_ready) mvalid = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          idx;
        reset = 1'b0; fetch_req = 0; fetch_addr = 0; rsp_ready = 1;
        prog_we = 0; prog_addr = 0; prog_data = 0; clr_req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_instr", rsp_instr, 0);
        chk("reset_rsp_fault", rsp_fault, 0);
        chk("reset_fault_cnt", fault_cnt, 0);
        chk("reset_busy", busy, 1);
        reset = 1'b1;

        // 1: power-on sweep, then a fetch of cleared memory
        sweep_check("init_sweep");
        step(1, 32'h40, 0, 0, 0, 0);
        idle(1);

        // 2: program two words, fetch back to back
        step(0, 0, 1, 3, 32'h2004_0003, 0);
        step(0, 0, 1, 4, 32'h2001_0002, 0);
        step(1, 32'h0C, 0, 0, 0, 0);
        step(1, 32'h10, 0, 0, 0, 0);
        idle(2);

        // 3: stall for three cycles with a fetch pending on the input
        rsp_ready = 0;
        step(1, 32'h0C, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1; fetch_addr = 32'h10;
            @(negedge clk);
            chk("stall_instr", rsp_instr, 32'h2004_0003);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_fetch_ready", fetch_ready, 0);
            @(posedge clk); #1;
        end
        fetch_req = 0; rsp_ready = 1;
        idle(2);

        // 4: faulted fetches and counter saturation
        step(1, 32'h0E, 0, 0, 0, 0);
        step(1, 32'h400, 0, 0, 0, 0);
        chk("fault_cnt_two", fault_cnt, 2);
        for (int i = 0; i < 298; i++) step(1, 32'h400 + 4 * i, 0, 0, 0, 0);
        idle(1);
        chk("fault_cnt_sat", fault_cnt, 255);

        // 5: same-cycle write and fetch of one index
        step(1, 32'h14, 1, 5, 32'hDEAD_BEEF, 0);
        step(1, 32'h14, 0, 0, 0, 0);
        idle(2);

        // 6: stalled response through clr, then reset mid-sweep
        step(0, 0, 1, 7, 32'hCAFE_F00D, 0);
        rsp_ready = 0;
        step(1, 32'h14, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        repeat (9) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("clr_busy", busy, 1);
        chk("clr_held_valid", rsp_valid, 1);
        chk("clr_held_instr", rsp_instr, 32'hDEAD_BEEF);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_instr", rsp_instr, 0);
        chk("abort_fault_cnt", fault_cnt, 0);
        chk("abort_busy", busy, 1);
        fcnt = 0;
        rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        sweep_check("restart_sweep");
        step(1, 32'h1C, 0, 0, 0, 0);
        step(1, 32'h08, 0, 0, 0, 0);
        step(1, 32'h14, 0, 0, 0, 0);
        idle(2);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            idx = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0: a = BASE + 4 * idx;
                1: a = BASE + 4 * idx + $urandom_range(1, 3);
                2: a = $urandom;
                default: a = ($urandom_range(0, 1) != 0) ? BASE + 4 * (DEPTH - 1) : BASE + 4 * DEPTH;
            endcase
            step($urandom_range(0, 1), a, ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 15), $urandom, 0);
        end
        rsp_ready = 1;
        idle(3);
        chk("sb_drained", sb.size(), 0);
        chk("fault_cnt_random", fault_cnt, fcnt);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
